// File: rtl/e_mdu_pkg.sv
// Shared definitions for the E-stage multiply/divide unit: op codes and
// default latency constants.
package e_mdu_pkg;

  typedef enum logic [3:0] {
    MDU_none  = 4'd0,
    MDU_mult  = 4'd1,
    MDU_multu = 4'd2,
    MDU_div   = 4'd3,
    MDU_divu  = 4'd4,
    MDU_mfhi  = 4'd5,
    MDU_mflo  = 4'd6,
    MDU_mthi  = 4'd7,
    MDU_mtlo  = 4'd8
  } mdu_op_e;

  localparam int unsigned MDU_WIDTH_DEF       = 32;
  localparam int unsigned MDU_MULT_CYCLES_DEF = 5;
  localparam int unsigned MDU_DIV_CYCLES_DEF  = 10;

endpackage

// File: rtl/e_mdu_core.sv
// Combinational arithmetic for the MDU: signed/unsigned product and
// quotient/remainder, with divide-by-zero suppression and overflow handling.
module e_mdu_core
  import e_mdu_pkg::*;
#(
  parameter int unsigned WIDTH = MDU_WIDTH_DEF
) (
  input  logic [3:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             wr_o
);

  logic [2*WIDTH-1:0] prod_s;
  logic [2*WIDTH-1:0] prod_u;
  logic               neg_a;
  logic               neg_b;
  logic               is_div;
  logic [WIDTH-1:0]   num;
  logic [WIDTH-1:0]   den;
  logic [WIDTH-1:0]   uq;
  logic [WIDTH-1:0]   ur;

  assign prod_s = {{WIDTH{a_i[WIDTH-1]}}, a_i} * {{WIDTH{b_i[WIDTH-1]}}, b_i};
  assign prod_u = {{WIDTH{1'b0}}, a_i} * {{WIDTH{1'b0}}, b_i};

  // Signed division runs on magnitudes; most-negative / -1 then falls out as
  // quotient = most-negative, remainder = 0 without a special case.
  assign neg_a  = a_i[WIDTH-1];
  assign neg_b  = b_i[WIDTH-1];
  assign is_div = (op_i == MDU_div);
  assign num    = (is_div && neg_a) ? -a_i : a_i;
  assign den    = (b_i == '0) ? WIDTH'(1) : ((is_div && neg_b) ? -b_i : b_i);
  assign uq     = num / den;
  assign ur     = num % den;

  always_comb begin
    hi_o = '0;
    lo_o = '0;
    wr_o = 1'b0;
    case (op_i)
      MDU_mult: begin
        {hi_o, lo_o} = prod_s;
        wr_o         = 1'b1;
      end
      MDU_multu: begin
        {hi_o, lo_o} = prod_u;
        wr_o         = 1'b1;
      end
      MDU_div: begin
        lo_o = (neg_a ^ neg_b) ? -uq : uq;
        hi_o = neg_a ? -ur : ur;
        wr_o = (b_i != '0);
      end
      MDU_divu: begin
        lo_o = uq;
        hi_o = ur;
        wr_o = (b_i != '0);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: owns HI/LO, models multi-cycle latency with a
// countdown, and serves mult/div and the HI/LO move instructions.
module e_mdu
  import e_mdu_pkg::*;
#(
  parameter int unsigned WIDTH       = MDU_WIDTH_DEF,
  parameter int unsigned MULT_CYCLES = MDU_MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = MDU_DIV_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       MDUOp,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic [WIDTH-1:0] C
);

  localparam int unsigned MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CW   = $clog2(MAXC + 1);

  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] tmp_hi_q;
  logic [WIDTH-1:0] tmp_lo_q;
  logic             tmp_wr_q;
  logic [WIDTH-1:0] core_hi;
  logic [WIDTH-1:0] core_lo;
  logic             core_wr;

  e_mdu_core #(.WIDTH(WIDTH)) u_core (
    .op_i (MDUOp),
    .a_i  (A),
    .b_i  (B),
    .hi_o (core_hi),
    .lo_o (core_lo),
    .wr_o (core_wr)
  );

  // Any op seen while busy is dropped: the busy branch takes priority over issue.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      tmp_hi_q <= '0;
      tmp_lo_q <= '0;
      tmp_wr_q <= 1'b0;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CW'(1);
      if (cnt_q == CW'(1) && tmp_wr_q) begin
        hi_q <= tmp_hi_q;
        lo_q <= tmp_lo_q;
      end
    end else if (start) begin
      case (MDUOp)
        MDU_mult, MDU_multu: begin
          cnt_q    <= CW'(MULT_CYCLES);
          tmp_hi_q <= core_hi;
          tmp_lo_q <= core_lo;
          tmp_wr_q <= core_wr;
        end
        MDU_div, MDU_divu: begin
          cnt_q    <= CW'(DIV_CYCLES);
          tmp_hi_q <= core_hi;
          tmp_lo_q <= core_lo;
          tmp_wr_q <= core_wr;
        end
        MDU_mthi: hi_q <= A;
        MDU_mtlo: lo_q <= A;
        default: ;
      endcase
    end
  end

  assign busy = (cnt_q != '0);
  assign HI   = hi_q;
  assign LO   = lo_q;

  always_comb begin
    C = '0;
    case (MDUOp)
      MDU_mfhi: C = hi_q;
      MDU_mflo: C = lo_q;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_e_mdu.sv
// Directed bench for e_mdu: default 32-bit instance plus a 16-bit, short-latency instance.
module tb_e_mdu;
  import e_mdu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  op;
  logic [31:0] a, b;
  logic        busy;
  logic [31:0] hi, lo, c;

  logic        start2;
  logic [3:0]  op2;
  logic [15:0] a2, b2;
  logic        busy2;
  logic [15:0] hi2, lo2, c2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  e_mdu u_dut (
    .clk(clk), .reset(rst_n), .start(start), .MDUOp(op), .A(a), .B(b),
    .busy(busy), .HI(hi), .LO(lo), .C(c)
  );

  e_mdu #(.WIDTH(16), .MULT_CYCLES(1), .DIV_CYCLES(3)) u_dut16 (
    .clk(clk), .reset(rst_n), .start(start2), .MDUOp(op2), .A(a2), .B(b2),
    .busy(busy2), .HI(hi2), .LO(lo2), .C(c2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1; op = o; a = x; b = y;
    tick();
    start = 1'b0; op = MDU_none;
  endtask

  task automatic do_issue2(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y);
    start2 = 1'b1; op2 = o; a2 = x; b2 = y;
    tick();
    start2 = 1'b0; op2 = MDU_none;
  endtask

  // Counts cycles with busy high after the issue edge, bounded.
  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 100) begin
      n++;
      tick();
    end
  endtask

  task automatic wait_idle2(output int n);
    n = 0;
    while (busy2 && n < 100) begin
      n++;
      tick();
    end
  endtask

  task automatic test_reset();
    n_checks++;
    if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0 || c !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b hi=%h lo=%h c=%h, required 0/0/0/0", busy, hi, lo, c);
    end
    do_issue(MDU_mult, 32'hFFFF_FFFE, 32'd3);
    tick(); tick();
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_inflight_busy: busy=%b, required 1", busy);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_checks++;
    if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_abort: busy=%b hi=%h lo=%h, required 0/0/0", busy, hi, lo);
    end
    repeat (12) tick();
    n_checks++;
    if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_no_late_write: busy=%b hi=%h lo=%h, required 0/0/0", busy, hi, lo);
    end
  endtask

  task automatic test_mult();
    int n;
    do_issue(MDU_mult, 32'hFFFF_FFFE, 32'd3);
    wait_idle(n);
    n_checks++;
    if (n !== 5 || hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFA) begin
      n_fail++;
      $display("FAIL mult_signed: cycles=%0d hi=%h lo=%h, required 5 FFFFFFFF FFFFFFFA", n, hi, lo);
    end
    do_issue(MDU_multu, 32'hFFFF_FFFE, 32'd3);
    wait_idle(n);
    n_checks++;
    if (n !== 5 || hi !== 32'h0000_0002 || lo !== 32'hFFFF_FFFA) begin
      n_fail++;
      $display("FAIL multu: cycles=%0d hi=%h lo=%h, required 5 00000002 FFFFFFFA", n, hi, lo);
    end
  endtask

  task automatic test_div();
    int n;
    do_issue(MDU_div, 32'hFFFF_FFF9, 32'd2);
    wait_idle(n);
    n_checks++;
    if (n !== 10 || hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin
      n_fail++;
      $display("FAIL div_signed: cycles=%0d hi=%h lo=%h, required 10 FFFFFFFF FFFFFFFD", n, hi, lo);
    end
    do_issue(MDU_divu, 32'd7, 32'd2);
    wait_idle(n);
    n_checks++;
    if (n !== 10 || hi !== 32'd1 || lo !== 32'd3) begin
      n_fail++;
      $display("FAIL divu: cycles=%0d hi=%h lo=%h, required 10 00000001 00000003", n, hi, lo);
    end
  endtask

  task automatic test_div_corner();
    int n;
    do_issue(MDU_mthi, 32'h1111_1111, 32'd0);
    do_issue(MDU_mtlo, 32'h2222_2222, 32'd0);
    do_issue(MDU_div, 32'd5, 32'd0);
    wait_idle(n);
    n_checks++;
    if (n !== 10 || hi !== 32'h1111_1111 || lo !== 32'h2222_2222) begin
      n_fail++;
      $display("FAIL div_by_zero: cycles=%0d hi=%h lo=%h, required 10 11111111 22222222", n, hi, lo);
    end
    do_issue(MDU_div, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(n);
    n_checks++;
    if (n !== 10 || hi !== 32'h0 || lo !== 32'h8000_0000) begin
      n_fail++;
      $display("FAIL div_overflow: cycles=%0d hi=%h lo=%h, required 10 00000000 80000000", n, hi, lo);
    end
  endtask

  task automatic test_move();
    do_issue(MDU_mthi, 32'hDEAD_BEEF, 32'd0);
    n_checks++;
    if (hi !== 32'hDEAD_BEEF || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL mthi: hi=%h busy=%b, required DEADBEEF 0", hi, busy);
    end
    start = 1'b1; op = MDU_mfhi;
    #1;
    n_checks++;
    if (c !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL mfhi: c=%h, required DEADBEEF", c);
    end
    op = MDU_mflo;
    #1;
    n_checks++;
    if (c !== 32'h8000_0000) begin
      n_fail++;
      $display("FAIL mflo: c=%h, required 80000000", c);
    end
    op = MDU_mthi;
    #1;
    n_checks++;
    if (c !== 32'h0) begin
      n_fail++;
      $display("FAIL c_other_op: c=%h, required 00000000", c);
    end
    // Unrecognised op and start=0 both leave state untouched.
    op = 4'hF; a = 32'h5555_5555;
    tick();
    start = 1'b0; op = MDU_mtlo;
    tick();
    op = MDU_none;
    n_checks++;
    if (hi !== 32'hDEAD_BEEF || lo !== 32'h8000_0000 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL no_effect_ops: hi=%h lo=%h busy=%b, required DEADBEEF 80000000 0", hi, lo, busy);
    end
  endtask

  task automatic test_busy_ignore();
    int n;
    do_issue(MDU_mult, 32'd4, 32'd5);
    do_issue(MDU_mtlo, 32'h1234_5678, 32'd0);
    n_checks++;
    if (lo !== 32'h8000_0000 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL mtlo_while_busy: lo=%h busy=%b, required 80000000 1", lo, busy);
    end
    do_issue(MDU_divu, 32'd100, 32'd7);
    wait_idle(n);
    n_checks++;
    if (n !== 3 || hi !== 32'h0 || lo !== 32'd20) begin
      n_fail++;
      $display("FAIL busy_ignore_result: cycles=%0d hi=%h lo=%h, required 3 00000000 00000014", n, hi, lo);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    do_issue(MDU_mult, 32'd6, 32'd7);
    wait_idle(n);
    n_checks++;
    if (n !== 5 || lo !== 32'd42) begin
      n_fail++;
      $display("FAIL b2b_first: cycles=%0d lo=%h, required 5 0000002A", n, lo);
    end
    do_issue(MDU_mult, 32'hFFFF_FFFD, 32'hFFFF_FFFD);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_accept: busy=%b, required 1", busy);
    end
    wait_idle(n);
    n_checks++;
    if (n !== 5 || hi !== 32'h0 || lo !== 32'd9) begin
      n_fail++;
      $display("FAIL b2b_second: cycles=%0d hi=%h lo=%h, required 5 00000000 00000009", n, hi, lo);
    end
  endtask

  task automatic test_param16();
    int n;
    do_issue2(MDU_mult, 16'hFFFE, 16'd3);
    wait_idle2(n);
    n_checks++;
    if (n !== 1 || hi2 !== 16'hFFFF || lo2 !== 16'hFFFA) begin
      n_fail++;
      $display("FAIL mult16: cycles=%0d hi=%h lo=%h, required 1 FFFF FFFA", n, hi2, lo2);
    end
    do_issue2(MDU_div, 16'hFFF9, 16'd2);
    wait_idle2(n);
    n_checks++;
    if (n !== 3 || hi2 !== 16'hFFFF || lo2 !== 16'hFFFD) begin
      n_fail++;
      $display("FAIL div16: cycles=%0d hi=%h lo=%h, required 3 FFFF FFFD", n, hi2, lo2);
    end
    do_issue2(MDU_multu, 16'hFFFE, 16'd3);
    wait_idle2(n);
    n_checks++;
    if (n !== 1 || hi2 !== 16'h0002 || lo2 !== 16'hFFFA) begin
      n_fail++;
      $display("FAIL multu16: cycles=%0d hi=%h lo=%h, required 1 0002 FFFA", n, hi2, lo2);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; op = MDU_none; a = '0; b = '0;
    start2 = 1'b0; op2 = MDU_none; a2 = '0; b2 = '0;
    tick(); tick();
    rst_n = 1'b1;
    test_reset();
    test_mult();
    test_div();
    test_div_corner();
    test_move();
    test_busy_ignore();
    test_back_to_back();
    test_param16();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
